// File: rtl/disp_sequencer_pkg.sv
// Shared definitions for the display sequencer: mode codes, the idle
// pattern and the digit positions used by the score and ID images.
package disp_pkg;

  localparam logic [2:0] MODE_IDLE  = 3'd0;
  localparam logic [2:0] MODE_LEVEL = 3'd1;
  localparam logic [2:0] MODE_GAME  = 3'd2;
  localparam logic [2:0] MODE_OVER  = 3'd3;
  localparam logic [2:0] MODE_TOPR  = 3'd4;
  localparam logic [2:0] MODE_TOPS  = 3'd5;

  localparam logic [7:0] DASH_DEFAULT = 8'b00111111;

  // Digit positions shared by the score and top-scorer images.
  localparam int SCORE_LO    = 2;
  localparam int SCORE_HI    = 3;
  localparam int ID_FIRST    = 1;
  localparam int ID_DIGITS   = 4;
  localparam int GAME_DIGITS = 6;

endpackage

// File: rtl/disp_sequencer_if.sv
// Source and display signals between the game controller/scorer and the
// display sequencer.
interface disp_sequencer_if #(
  parameter int NUM_DIGITS = 6,
  parameter int SEG_W      = 8
);
  // No valid/ready handshake: every source is a level signal sampled on
  // every clk edge, and disp_bus/rot_phase are always valid after reset.
  logic [2:0]                  mode;
  logic [SEG_W-1:0]            mode_disp;
  logic [NUM_DIGITS*SEG_W-1:0] scram_bus;
  logic [2*SEG_W-1:0]          player_score;
  logic [4*SEG_W-1:0]          top_id;
  logic [2*SEG_W-1:0]          top_score;
  logic                        freeze;
  logic [NUM_DIGITS*SEG_W-1:0] disp_bus;
  logic                        rot_phase;

  modport master (
    output mode, mode_disp, scram_bus, player_score, top_id, top_score, freeze,
    input  disp_bus, rot_phase
  );

  modport slave (
    input  mode, mode_disp, scram_bus, player_score, top_id, top_score, freeze,
    output disp_bus, rot_phase
  );
endinterface

// File: rtl/disp_sequencer_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV cycles.
// clr restarts the count (and suppresses a coinciding tick); hold freezes it.
module tick_prescaler #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic tick
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST) && !clr && !hold;

  // Count 0..TICK_DIV-1, restarting on clr and standing still on hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/disp_sequencer.sv
// Display sequencer: picks per-digit segment patterns from the mode code,
// blinks the game-over score a bounded number of times and rotates the
// top-scorer view between ID and score.
module disp_sequencer
  import disp_pkg::*;
#(
  parameter int               NUM_DIGITS  = 6,
  parameter int               SEG_W       = 8,
  parameter logic [SEG_W-1:0] DASH        = SEG_W'(DASH_DEFAULT),
  parameter int               TICK_DIV    = 25000000,
  parameter int               BLINK_TICKS = 1,
  parameter int               BLINK_COUNT = 3,
  parameter int               ROT_TICKS   = 4
) (
  input logic             clk,
  input logic             rst,
  disp_sequencer_if.slave bus
);
  localparam int TOG_MAX = 2 * BLINK_COUNT;
  localparam int BT_W    = $clog2(BLINK_TICKS + 1);
  localparam int TG_W    = $clog2(TOG_MAX + 1);
  localparam int RT_W    = $clog2(ROT_TICKS + 1);
  localparam int DW      = NUM_DIGITS * SEG_W;

  logic [2:0]      mode_q;
  logic            mode_chg;
  logic            tick;
  logic [BT_W-1:0] b_tcnt, b_tcnt_n;
  logic [TG_W-1:0] b_tog, b_tog_n;
  logic            b_ph, b_ph_n;
  logic [RT_W-1:0] r_tcnt, r_tcnt_n;
  logic            r_ph, r_ph_n;
  logic [DW-1:0]   disp_q, disp_n;

  // Phase-dependent image for a mode; unlisted digits show DASH.
  function automatic logic [DW-1:0] image(
    input logic [2:0]         m,
    input logic               bph,
    input logic               rph,
    input logic [SEG_W-1:0]   md,
    input logic [DW-1:0]      scr,
    input logic [2*SEG_W-1:0] ps,
    input logic [4*SEG_W-1:0] tid,
    input logic [2*SEG_W-1:0] ts
  );
    logic [DW-1:0] img;
    img = {NUM_DIGITS{DASH}};
    case (m)
      MODE_LEVEL: img[0 +: SEG_W] = md;
      MODE_GAME: begin
        for (int i = 0; i < GAME_DIGITS; i++) img[i*SEG_W +: SEG_W] = scr[i*SEG_W +: SEG_W];
      end
      MODE_OVER: begin
        if (!bph) begin
          img[SCORE_LO*SEG_W +: SEG_W] = ps[0 +: SEG_W];
          img[SCORE_HI*SEG_W +: SEG_W] = ps[SEG_W +: SEG_W];
        end
      end
      MODE_TOPR: begin
        if (!rph) begin
          for (int i = 0; i < ID_DIGITS; i++) img[(ID_FIRST+i)*SEG_W +: SEG_W] = tid[i*SEG_W +: SEG_W];
        end else begin
          img[SCORE_LO*SEG_W +: SEG_W] = ts[0 +: SEG_W];
          img[SCORE_HI*SEG_W +: SEG_W] = ts[SEG_W +: SEG_W];
        end
      end
      MODE_TOPS: begin
        img[SCORE_LO*SEG_W +: SEG_W] = ts[0 +: SEG_W];
        img[SCORE_HI*SEG_W +: SEG_W] = ts[SEG_W +: SEG_W];
      end
      default: ;
    endcase
    return img;
  endfunction

  assign mode_chg = (bus.mode != mode_q);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (mode_chg),
    .hold (bus.freeze),
    .tick (tick)
  );

  // Next blink/rotation phase on a tick, and the image to register.
  always_comb begin
    b_tcnt_n = b_tcnt;
    b_tog_n  = b_tog;
    b_ph_n   = b_ph;
    r_tcnt_n = r_tcnt;
    r_ph_n   = r_ph;
    if (tick && mode_q == MODE_OVER && b_tog != TG_W'(TOG_MAX)) begin
      if (b_tcnt == BT_W'(BLINK_TICKS - 1)) begin
        b_tcnt_n = '0;
        b_ph_n   = ~b_ph;
        b_tog_n  = b_tog + TG_W'(1);
      end else begin
        b_tcnt_n = b_tcnt + BT_W'(1);
      end
    end
    if (tick && mode_q == MODE_TOPR) begin
      if (r_tcnt == RT_W'(ROT_TICKS - 1)) begin
        r_tcnt_n = '0;
        r_ph_n   = ~r_ph;
      end else begin
        r_tcnt_n = r_tcnt + RT_W'(1);
      end
    end
    if (mode_chg) begin
      disp_n = image(bus.mode, 1'b0, 1'b0, bus.mode_disp, bus.scram_bus,
                     bus.player_score, bus.top_id, bus.top_score);
    end else begin
      disp_n = image(mode_q, b_ph_n, r_ph_n, bus.mode_disp, bus.scram_bus,
                     bus.player_score, bus.top_id, bus.top_score);
    end
  end

  // Mode change restarts all phases and beats freeze; freeze holds everything else.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q <= MODE_IDLE;
      b_tcnt <= '0;
      b_tog  <= '0;
      b_ph   <= 1'b0;
      r_tcnt <= '0;
      r_ph   <= 1'b0;
      disp_q <= {NUM_DIGITS{DASH}};
    end else if (mode_chg) begin
      mode_q <= bus.mode;
      b_tcnt <= '0;
      b_tog  <= '0;
      b_ph   <= 1'b0;
      r_tcnt <= '0;
      r_ph   <= 1'b0;
      disp_q <= disp_n;
    end else if (!bus.freeze) begin
      b_tcnt <= b_tcnt_n;
      b_tog  <= b_tog_n;
      b_ph   <= b_ph_n;
      r_tcnt <= r_tcnt_n;
      r_ph   <= r_ph_n;
      disp_q <= disp_n;
    end
  end

  assign bus.disp_bus  = disp_q;
  assign bus.rot_phase = r_ph && (mode_q == MODE_TOPR);
endmodule

// File: tb/tb_disp_sequencer.sv
// Bench for disp_sequencer: scripted scenarios with literal expectations,
// then randomized modes/data/freeze/reset checked every cycle against a
// model that derives the image from time spent in the current mode.
module tb_disp_sequencer;
  localparam int ND = 8;
  localparam int TD = 4;
  localparam int BT = 1;
  localparam int BC = 3;
  localparam int RT = 2;
  localparam int W  = 1 + ND * 8;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [W-1:0] exp_q[$];

  disp_sequencer_if #(.NUM_DIGITS(ND), .SEG_W(8)) bus ();

  disp_sequencer #(
    .NUM_DIGITS (ND),
    .SEG_W      (8),
    .DASH       (8'h3F),
    .TICK_DIV   (TD),
    .BLINK_TICKS(BT),
    .BLINK_COUNT(BC),
    .ROT_TICKS  (RT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected {rot_phase, disp_bus} after e unfrozen cycles in mode m.
  function automatic logic [W-1:0] model_img(input int m, input int e, input logic [7:0] md,
                                             input logic [ND*8-1:0] scr, input logic [15:0] ps,
                                             input logic [31:0] tid, input logic [15:0] ts);
    int ticks;
    int tog;
    logic rp;
    logic [ND*8-1:0] d;
    ticks = e / TD;
    rp = 1'b0;
    d = {ND{8'h3F}};
    case (m)
      1: d[7:0] = md;
      2: d[47:0] = scr[47:0];
      3: begin
        tog = ticks / BT;
        if (tog > 2 * BC) tog = 2 * BC;
        if (tog % 2 == 0) d[31:16] = ps;
      end
      4: begin
        rp = ((ticks / RT) % 2) == 1;
        if (!rp) d[39:8] = tid;
        else d[31:16] = ts;
      end
      5: d[31:16] = ts;
      default: ;
    endcase
    return {rp, d};
  endfunction

  // Reference model: time-in-mode counter, sampled at each active edge.
  int m_mode = 0;
  int m_e = 0;
  logic [W-1:0] m_exp = {1'b0, {ND{8'h3F}}};
  always @(posedge clk) begin
    if (!rst) begin
      m_mode = 0;
      m_e = 0;
      m_exp = {1'b0, {ND{8'h3F}}};
    end else if (int'(bus.mode) != m_mode) begin
      m_mode = int'(bus.mode);
      m_e = 0;
      m_exp = model_img(m_mode, m_e, bus.mode_disp, bus.scram_bus, bus.player_score, bus.top_id, bus.top_score);
    end else if (!bus.freeze) begin
      m_e++;
      m_exp = model_img(m_mode, m_e, bus.mode_disp, bus.scram_bus, bus.player_score, bus.top_id, bus.top_score);
    end
    exp_q.push_back(m_exp);
  end

  // Scoreboard: every cycle, compare the registered outputs with the model.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle", {bus.rot_phase, bus.disp_bus}, e);
    end
  end

  // Driver
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  localparam logic [W-1:0] ALL_DASH  = {1'b0, {ND{8'h3F}}};
  localparam logic [W-1:0] SCORE_IMG = {1'b0, 64'h3F3F3F3F5B063F3F};
  localparam logic [W-1:0] ID_IMG    = {1'b0, 64'h3F3F3FA1B2C3D43F};
  localparam logic [W-1:0] TS_IMG1   = {1'b1, 64'h3F3F3F3F7D6D3F3F};
  localparam logic [W-1:0] TS_IMG0   = {1'b0, 64'h3F3F3F3F7D6D3F3F};

  initial begin
    rst = 1'b0;
    bus.mode = 3'd2;
    bus.mode_disp = 8'h00;
    bus.scram_bus = 64'h1122334455667788;
    bus.player_score = 16'h5B06;
    bus.top_id = 32'hA1B2C3D4;
    bus.top_score = 16'h7D6D;
    bus.freeze = 1'b0;

    // Reset with mode 2 requested, then scrambled letters one cycle after release.
    step(2);
    check("reset_disp", {1'b0, bus.disp_bus}, ALL_DASH);
    check("reset_rot", {64'd0, bus.rot_phase}, '0);
    rst = 1'b1;
    step(1);
    check("game_after_reset", {bus.rot_phase, bus.disp_bus}, {1'b0, 64'h3F3F334455667788});
    for (int i = 0; i < 6; i++) begin
      bus.scram_bus = {$urandom, $urandom};
      step(1);
    end

    // Level select follows mode_disp with one cycle latency.
    bus.mode = 3'd1;
    bus.mode_disp = 8'h66;
    step(1);
    check("level_66", {bus.rot_phase, bus.disp_bus}, {1'b0, 64'h3F3F3F3F3F3F3F66});
    bus.mode_disp = 8'h4F;
    step(1);
    check("level_4F", {bus.rot_phase, bus.disp_bus}, {1'b0, 64'h3F3F3F3F3F3F3F4F});

    // Game over: blink three full cycles then steady score.
    bus.mode = 3'd3;
    step(1);
    check("over_score", {bus.rot_phase, bus.disp_bus}, SCORE_IMG);
    step(4);
    check("over_dash", {bus.rot_phase, bus.disp_bus}, ALL_DASH);
    step(60);
    check("over_steady", {bus.rot_phase, bus.disp_bus}, SCORE_IMG);

    // Top-scorer rotation, freeze mid-rotation, then steady top score.
    bus.mode = 3'd4;
    step(1);
    check("rot_id", {bus.rot_phase, bus.disp_bus}, ID_IMG);
    step(8);
    check("rot_score", {bus.rot_phase, bus.disp_bus}, TS_IMG1);
    step(3);
    bus.freeze = 1'b1;
    step(20);
    bus.freeze = 1'b0;
    step(13);
    bus.mode = 3'd5;
    step(1);
    check("tops_steady", {bus.rot_phase, bus.disp_bus}, TS_IMG0);

    // Mode change landing on a tick: rotation starts fresh.
    bus.mode = 3'd3;
    step(4);
    bus.mode = 3'd4;
    step(1);
    check("tick_chg_id", {bus.rot_phase, bus.disp_bus}, ID_IMG);
    step(7);
    check("tick_chg_pre", {64'd0, bus.rot_phase}, '0);
    step(1);
    check("tick_chg_toggle", {64'd0, bus.rot_phase}, {64'd0, 1'b1});

    // Randomized modes, data, freeze and occasional reset.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 11) == 0) bus.mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) bus.mode_disp = 8'($urandom);
      if ($urandom_range(0, 2) == 0) bus.scram_bus = {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) bus.player_score = 16'($urandom);
      if ($urandom_range(0, 5) == 0) bus.top_id = $urandom;
      if ($urandom_range(0, 5) == 0) bus.top_score = 16'($urandom);
      if ($urandom_range(0, 7) == 0) bus.freeze = ~bus.freeze;
      rst = ($urandom_range(0, 149) != 0);
      step(1);
    end
    rst = 1'b1;
    bus.freeze = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
